nested_loop_counter: RTL and testbench
======================================

# nested_loop_counter

Parametrised multi-dimensional loop counter generating index tuples for tiled accelerator loops (e.g. GEMM M/N/K tiling). It chains `NumLoops` ceiling counters with carry propagation, latches per-loop ceilings on a start command, and streams one index tuple per cycle over a valid/ready handshake. It sits between the control/CSR layer and address generators or streamers, and signals completion with a single-cycle done pulse.

## Interface
- `NumLoops`, 3, number of nested loops; loop 0 is innermost (fastest-changing); must be >= 1.
- `Width`, 8, bit width of each ceiling and index.
- `clk_i`  input  1  clock; all state updates on the rising edge.
- `rst_ni`  input  1  reset, asynchronous, active-low.
- `start_i`  input  1  start command; accepted only in IDLE.
- `clear_i`  input  1  synchronous abort, active-high; priority over everything except reset.
- `ceilings_i`  input  NumLoops x Width  per-loop trip counts; sampled only when start is accepted.
- `ready_i`  input  1  consumer ready.
- `valid_o`  output  1  index tuple valid.
- `idx_o`  output  NumLoops x Width  current index tuple, registered.
- `last_o`  output  NumLoops  per-loop wrap flags for the current tuple.
- `busy_o`  output  1  high in RUN.
- `done_o`  output  1  single-cycle completion pulse.

## Operation
- States: IDLE, RUN.
- IDLE: `valid_o`=0 and `busy_o`=0. If `start_i`=1, latch `ceilings_i` into internal registers, zero all indices, and go to RUN.
- Ceiling value 0 is latched as 1: that loop runs a single iteration. No error is raised.
- RUN: `valid_o`=1 and `busy_o`=1. A handshake is `valid_o && ready_i`.
- `wrap[k]` = (`idx[k]` == `ceil[k]`-1). `last_o[k]` = `valid_o` AND `wrap[0]` AND ... AND `wrap[k]` (carry chain), computed combinationally from registered state.
- On a handshake, each loop k updates as follows:
  - k=0, or `last_o[k-1]`=1: increment `idx[k]`, or reset it to 0 if `wrap[k]`.
  - Otherwise: `idx[k]` holds.
- A handshake with `last_o[NumLoops-1]`=1 is the final tuple. All indices return to 0, the state goes to IDLE, and `done_o`=1 in the next cycle.
- Without a handshake, `idx_o` is stable while `valid_o` is high. No tuple is dropped or repeated.
- Total handshakes per run = product of the effective ceilings. Tuple order is lexicographic with loop 0 fastest.
- `start_i` in RUN is ignored. That includes the cycle of the final handshake.
- `start_i` in the cycle where `done_o`=1 is accepted, because the block is already in IDLE.
- `clear_i`=1 in any state: go to IDLE, zero all indices, `done_o`=0 next cycle. `clear_i` and `start_i` together: clear wins and start is dropped.
- Index arithmetic is unsigned, `Width` bits. The comparison against `ceil`-1 is done at `Width` bits, so ceiling 2^Width-1 is supported.
- Reset mid-run: asynchronously return to IDLE. The latched ceilings and the in-flight run are discarded.

## Timing
- Reset values: `valid_o`=0, `idx_o`=0, `last_o`=0, `busy_o`=0, `done_o`=0, state IDLE, latched ceilings=1.
- `start_i` accepted at edge t: `valid_o`=1 with `idx_o`=0 from cycle t+1.
- Throughput: one tuple per cycle while `ready_i`=1.
- Final handshake at edge t: `valid_o`=0 and `done_o`=1 in cycle t+1; `done_o`=0 in cycle t+2 unless a new run also completes.
- Minimum run, all ceilings 1: start at t, tuple in t+1, done in t+2 if `ready_i`=1.
- `valid_o` does not depend combinationally on `ready_i`. `last_o` depends only on registered state.

## Test plan
- NumLoops=2, ceilings {3,2}, `ready_i`=1: six tuples (0,0),(1,0),(2,0),(0,1),(1,1),(2,1). `last_o`[0] on the 3rd and 6th tuples, `last_o`[1] on the 6th only. `done_o` one cycle later, `busy_o` low afterwards.
- Same configuration with `ready_i` toggling pseudo-randomly: identical tuple sequence, `idx_o` stable during stalls, exactly 6 handshakes, one `done_o`.
- Ceilings {0,1,1}: exactly one tuple (0,0,0) with all `last_o` bits high, then `done_o`. Ceilings {255,1,1}, Width=8: 255 tuples, and `idx[0]` reaches 254 then wraps to 0.
- `clear_i` after the 3rd handshake of a {4,4,4} run: `valid_o`=0 next cycle, no `done_o`. A following start with {2,1,1} yields (0,0,0),(1,0,0).
- `rst_ni` pulsed low mid-run: all outputs 0 immediately. `start_i` during RUN is ignored. `start_i` in the `done_o` cycle begins a new run with `valid_o` on the next cycle.

Source files
------------

// File: rtl/nested_loop_counter.sv
// nested_loop_counter: chained ceiling counters that stream one index tuple
// per handshake for tiled accelerator loops. Loop 0 is innermost.
//
// state | meaning
// IDLE  | no tuple offered; waits for start_i and latches the ceilings
// RUN   | tuple offered on idx_o; advances on every valid/ready handshake
module nested_loop_counter #(
  parameter int NumLoops = 3,
  parameter int Width    = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             start_i,
  input  logic                             clear_i,
  input  logic [NumLoops-1:0][Width-1:0]   ceilings_i,
  input  logic                             ready_i,
  output logic                             valid_o,
  output logic [NumLoops-1:0][Width-1:0]   idx_o,
  output logic [NumLoops-1:0]              last_o,
  output logic                             busy_o,
  output logic                             done_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                           state_q, state_d;
  logic [NumLoops-1:0][Width-1:0]   idx_q, idx_d;
  logic [NumLoops-1:0][Width-1:0]   ceil_q, ceil_d;
  logic                             done_q, done_d;
  logic [NumLoops-1:0]              wrap;
  logic [NumLoops-1:0]              last;
  logic                             valid;
  logic                             hs;

  // Wrap flags and the carry chain; compare at Width bits so a ceiling of
  // 2^Width-1 works and a latched ceiling is never zero.
  always_comb begin
    wrap  = '0;
    last  = '0;
    valid = (state_q == RUN);
    for (int k = 0; k < NumLoops; k++) begin
      wrap[k] = (idx_q[k] == (ceil_q[k] - Width'(1)));
    end
    last[0] = valid & wrap[0];
    for (int k = 1; k < NumLoops; k++) begin
      last[k] = last[k-1] & wrap[k];
    end
    hs = valid & ready_i;
  end

  // Next-state, index advance and ceiling capture; clear overrides all.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ceil_d  = ceil_q;
    done_d  = 1'b0;
    if (clear_i) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            for (int k = 0; k < NumLoops; k++) begin
              ceil_d[k] = (ceilings_i[k] == '0) ? Width'(1) : ceilings_i[k];
            end
            idx_d   = '0;
            state_d = RUN;
          end
        end
        RUN: begin
          if (hs) begin
            if (last[NumLoops-1]) begin
              idx_d   = '0;
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              idx_d[0] = wrap[0] ? '0 : idx_q[0] + Width'(1);
              for (int k = 1; k < NumLoops; k++) begin
                if (last[k-1]) begin
                  idx_d[k] = wrap[k] ? '0 : idx_q[k] + Width'(1);
                end
              end
            end
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
        end
      endcase
    end
  end

  // State, index, ceiling and done registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
      for (int k = 0; k < NumLoops; k++) begin
        ceil_q[k] <= Width'(1);
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ceil_q  <= ceil_d;
      done_q  <= done_d;
    end
  end

  assign valid_o = valid;
  assign busy_o  = valid;
  assign idx_o   = idx_q;
  assign last_o  = last;
  assign done_o  = done_q;

endmodule

// File: tb/tb_nested_loop_counter.sv
// Self-checking bench for nested_loop_counter with a flat-count reference model.
module tb_nested_loop_counter;

  localparam int NL = 3;
  localparam int W  = 8;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   start;
  logic                   clear;
  logic                   ready;
  logic [NL-1:0][W-1:0]   ceil_in;
  logic                   valid;
  logic [NL-1:0][W-1:0]   idx;
  logic [NL-1:0]          last;
  logic                   busy;
  logic                   done;

  int n_cmp = 0;
  int n_bad = 0;
  int eff[NL];

  nested_loop_counter #(.NumLoops(NL), .Width(W)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .start_i   (start),
    .clear_i   (clear),
    .ceilings_i(ceil_in),
    .ready_i   (ready),
    .valid_o   (valid),
    .idx_o     (idx),
    .last_o    (last),
    .busy_o    (busy),
    .done_o    (done)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Tuple number n decomposed as a mixed-radix number, loop 0 least significant.
  function automatic logic [NL*W-1:0] ref_idx(input int n);
    logic [NL-1:0][W-1:0] r;
    int rem;
    rem = n;
    for (int k = 0; k < NL; k++) begin
      r[k] = W'(rem % eff[k]);
      rem  = rem / eff[k];
    end
    return r;
  endfunction

  function automatic logic [NL-1:0] ref_last(input int n);
    logic [NL-1:0] l;
    bit all_w;
    int rem;
    rem   = n;
    all_w = 1'b1;
    for (int k = 0; k < NL; k++) begin
      all_w = all_w && ((rem % eff[k]) == eff[k] - 1);
      l[k]  = all_w;
      rem   = rem / eff[k];
    end
    return l;
  endfunction

  task automatic start_run(input int c0, input int c1, input int c2);
    ceil_in[0] = W'(c0);
    ceil_in[1] = W'(c1);
    ceil_in[2] = W'(c2);
    eff[0] = (c0 == 0) ? 1 : c0;
    eff[1] = (c1 == 0) ? 1 : c1;
    eff[2] = (c2 == 0) ? 1 : c2;
    start = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    ceil_in = NL*W'($urandom);
  endtask

  // Streams the whole run against the model; returns in the done cycle.
  task automatic stream(input bit rnd_ready, input bit rnd_start, input string tag);
    int total, n, cyc, budget;
    total  = eff[0] * eff[1] * eff[2];
    n      = 0;
    cyc    = 0;
    budget = total * 10 + 20;
    while (n < total && cyc < budget) begin
      check_val({tag, ".valid"}, 32'(valid), 32'd1);
      check_val({tag, ".busy"},  32'(busy),  32'd1);
      check_val({tag, ".idx"},   32'(idx),   32'(ref_idx(n)));
      check_val({tag, ".last"},  32'(last),  32'(ref_last(n)));
      check_val({tag, ".done"},  32'(done),  32'd0);
      ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      start = rnd_start ? 1'($urandom_range(0, 1)) : 1'b0;
      if (rnd_start) ceil_in = NL*W'($urandom);
      @(posedge clk); #1;
      if (ready) n++;
      cyc++;
    end
    start = 1'b0;
    if (n < total) check_val({tag, ".timeout"}, 32'd0, 32'd1);
    check_val({tag, ".end_valid"}, 32'(valid), 32'd0);
    check_val({tag, ".end_done"},  32'(done),  32'd1);
    check_val({tag, ".end_busy"},  32'(busy),  32'd0);
    check_val({tag, ".end_idx"},   32'(idx),   32'd0);
    check_val({tag, ".end_last"},  32'(last),  32'd0);
  endtask

  task automatic idle_check(input string tag);
    @(posedge clk); #1;
    check_val({tag, ".idle_done"},  32'(done),  32'd0);
    check_val({tag, ".idle_valid"}, 32'(valid), 32'd0);
    check_val({tag, ".idle_busy"},  32'(busy),  32'd0);
  endtask

  // Directed scenarios followed by randomized runs.
  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    clear   = 1'b0;
    ready   = 1'b0;
    ceil_in = '0;
    #2;
    check_val("rst.valid", 32'(valid), 32'd0);
    check_val("rst.idx",   32'(idx),   32'd0);
    check_val("rst.last",  32'(last),  32'd0);
    check_val("rst.busy",  32'(busy),  32'd0);
    check_val("rst.done",  32'(done),  32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("post_rst.valid", 32'(valid), 32'd0);

    start_run(3, 2, 1);
    stream(1'b0, 1'b0, "c32");
    idle_check("c32");

    start_run(3, 2, 1);
    stream(1'b1, 1'b1, "c32_rnd");
    idle_check("c32_rnd");

    start_run(1, 1, 1);
    stream(1'b0, 1'b0, "c111");
    idle_check("c111");

    start_run(0, 1, 1);
    stream(1'b0, 1'b0, "c011");
    idle_check("c011");

    start_run(255, 1, 1);
    stream(1'b0, 1'b0, "c255");
    start_run(2, 2, 1);
    stream(1'b1, 1'b0, "b2b");
    idle_check("b2b");

    start_run(4, 4, 4);
    ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check_val("clr.pre_idx", 32'(idx), 32'h000003);
    clear = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    start = 1'b0;
    check_val("clr.valid", 32'(valid), 32'd0);
    check_val("clr.busy",  32'(busy),  32'd0);
    check_val("clr.done",  32'(done),  32'd0);
    check_val("clr.idx",   32'(idx),   32'd0);
    idle_check("clr");
    start_run(2, 1, 1);
    stream(1'b0, 1'b0, "after_clr");
    idle_check("after_clr");

    start_run(4, 4, 4);
    ready = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    check_val("mid_rst.valid", 32'(valid), 32'd0);
    check_val("mid_rst.idx",   32'(idx),   32'd0);
    check_val("mid_rst.last",  32'(last),  32'd0);
    check_val("mid_rst.busy",  32'(busy),  32'd0);
    check_val("mid_rst.done",  32'(done),  32'd0);
    #2 rst_n = 1'b1;
    idle_check("mid_rst");

    for (int i = 0; i < 8; i++) begin
      start_run(int'($urandom_range(0, 5)), int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
      stream(1'b1, 1'b1, "rnd");
      if ($urandom_range(0, 1) == 0) idle_check("rnd");
    end
    idle_check("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
